// File: rtl/pipe_hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard bundle: decoded ID fields in, stall/hold/forward selects out.
// Combinational interface; no flow control of its own.
interface pipe_hazard_scoreboard_if #(
    parameter int REG_ADDR_LEN = 4,
    parameter int SELW         = 2
);
    logic                    forward_EN;
    logic                    id_valid;
    logic [REG_ADDR_LEN-1:0] id_src1;
    logic [REG_ADDR_LEN-1:0] id_src2;
    logic                    id_src1_used;
    logic                    id_src2_used;
    logic [REG_ADDR_LEN-1:0] id_dest;
    logic                    id_wb_en;
    logic                    id_is_load;
    logic                    id_multi;
    logic                    flush;
    logic                    stall;
    logic                    ex_hold;
    logic [SELW-1:0]         fwd_sel1;
    logic [SELW-1:0]         fwd_sel2;
    logic [SELW-1:0]         inflight;

    modport master (
        output forward_EN, id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
               id_dest, id_wb_en, id_is_load, id_multi, flush,
        input  stall, ex_hold, fwd_sel1, fwd_sel2, inflight
    );

    modport slave (
        input  forward_EN, id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
               id_dest, id_wb_en, id_is_load, id_multi, flush,
        output stall, ex_hold, fwd_sel1, fwd_sel2, inflight
    );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding controller tracking DEPTH post-ID destination tags; HAZARD_STATS_EN adds event counters.
// Outputs are same-cycle combinational; shadow advances each clock, stage 1 frozen while a multi-cycle op is busy.
module pipe_hazard_scoreboard #(
    parameter int REG_ADDR_LEN = 4,
    parameter int DEPTH        = 3,
    parameter int LOAD_STAGE   = 2,
    parameter int MULTI_LAT    = 4,
    parameter int SELW         = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    pipe_hazard_scoreboard_if.slave  sb
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              hold_cnt,
    output logic [31:0]              fwd_cnt
`endif
);
    localparam int CW = $clog2(MULTI_LAT);

    logic [DEPTH:1]          v_q, v_d, wb_q, wb_d, ld_q, ld_d;
    logic [REG_ADDR_LEN-1:0] dest_q [1:DEPTH];
    logic [REG_ADDR_LEN-1:0] dest_d [1:DEPTH];
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [DEPTH:1] hit1, hit2, fwdable;
    logic           hold, lu1, lu2, hz1, hz2, stall, issue;
    logic [SELW-1:0] sel1, sel2, inflight;

    always_comb begin
        hold = (cnt_q != '0);
        for (int k = 1; k <= DEPTH; k++) begin
            hit1[k] = v_q[k] && wb_q[k] && sb.id_src1_used && (sb.id_src1 != '0) && (dest_q[k] == sb.id_src1);
            hit2[k] = v_q[k] && wb_q[k] && sb.id_src2_used && (sb.id_src2 != '0) && (dest_q[k] == sb.id_src2);
            // a busy multi-cycle op in stage 1 has no result yet
            fwdable[k] = (!ld_q[k] || (k >= LOAD_STAGE)) && !((k == 1) && hold);
        end
    end

    always_comb begin
        sel1     = '0;
        sel2     = '0;
        lu1      = 1'b0;
        lu2      = 1'b0;
        inflight = '0;
        // scan oldest to youngest so the youngest match is what remains
        for (int k = DEPTH; k >= 1; k--) begin
            if (hit1[k] && fwdable[k]) sel1 = SELW'(k);
            if (hit2[k] && fwdable[k]) sel2 = SELW'(k);
            if (hit1[k]) lu1 = ld_q[k] && (k < LOAD_STAGE);
            if (hit2[k]) lu2 = ld_q[k] && (k < LOAD_STAGE);
            inflight = inflight + SELW'(v_q[k]);
        end
        // without forwarding, stage DEPTH is covered by register-file write-through
        hz1   = sb.forward_EN ? lu1 : |hit1[DEPTH-1:1];
        hz2   = sb.forward_EN ? lu2 : |hit2[DEPTH-1:1];
        stall = sb.id_valid && !sb.flush && (hold || hz1 || hz2);
        issue = sb.id_valid && !sb.flush && !stall;
    end

    assign sb.stall    = stall;
    assign sb.ex_hold  = hold;
    assign sb.fwd_sel1 = sb.forward_EN ? sel1 : '0;
    assign sb.fwd_sel2 = sb.forward_EN ? sel2 : '0;
    assign sb.inflight = inflight;

    always_comb begin
        v_d    = v_q;
        wb_d   = wb_q;
        ld_d   = ld_q;
        dest_d = dest_q;
        cnt_d  = cnt_q;
        if (hold) begin
            for (int k = DEPTH; k >= 3; k--) begin
                v_d[k]    = v_q[k-1];
                wb_d[k]   = wb_q[k-1];
                ld_d[k]   = ld_q[k-1];
                dest_d[k] = dest_q[k-1];
            end
            v_d[2]    = 1'b0;
            wb_d[2]   = 1'b0;
            ld_d[2]   = 1'b0;
            dest_d[2] = '0;
            cnt_d     = cnt_q - CW'(1);
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                v_d[k]    = v_q[k-1];
                wb_d[k]   = wb_q[k-1];
                ld_d[k]   = ld_q[k-1];
                dest_d[k] = dest_q[k-1];
            end
            v_d[1]    = issue;
            wb_d[1]   = sb.id_wb_en;
            ld_d[1]   = sb.id_is_load;
            dest_d[1] = sb.id_dest;
            if (issue && sb.id_multi) cnt_d = CW'(MULTI_LAT - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            wb_q  <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
            for (int k = 1; k <= DEPTH; k++) dest_q[k] <= '0;
        end else begin
            v_q    <= v_d;
            wb_q   <= wb_d;
            ld_q   <= ld_d;
            cnt_q  <= cnt_d;
            dest_q <= dest_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, hold_cnt_q, hold_cnt_d, fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (hold && (hold_cnt_q != '1)) hold_cnt_d = hold_cnt_q + 32'd1;
        if (((sb.fwd_sel1 != '0) || (sb.fwd_sel2 != '0)) && (fwd_cnt_q != '1))
            fwd_cnt_d = fwd_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            hold_cnt_q  <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign hold_cnt  = hold_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of in-flight instructions.
module tb_pipe_hazard_scoreboard;
    localparam int RAL        = 4;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 2;
    localparam int MULTI_LAT  = 4;
    localparam int SELW       = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_scoreboard_if #(.REG_ADDR_LEN(RAL), .SELW(SELW)) bus();
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, hold_cnt, fwd_cnt;
`endif

    pipe_hazard_scoreboard #(
        .REG_ADDR_LEN(RAL), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE),
        .MULTI_LAT(MULTI_LAT), .SELW(SELW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb(bus)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .hold_cnt(hold_cnt),
        .fwd_cnt(fwd_cnt)
`endif
    );

    typedef struct {
        bit v;
        bit wb;
        bit ld;
        int dest;
    } ent_t;

    ent_t pipe   [1:DEPTH];
    ent_t pipe_n [1:DEPTH];
    int   busy, busy_n;       // remaining cycles the multi-cycle op still occupies EXE
    bit   seen_rst;
    int   checks, errors;
    int   m_stall, m_hold, m_fwd, m_stall_n, m_hold_n, m_fwd_n;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(int k, int r);
        return pipe[k].v && pipe[k].wb && (pipe[k].dest == r) && (r != 0);
    endfunction

    function automatic int exp_sel(int r, bit used);
        if (!bus.forward_EN || !used) return 0;
        for (int k = 1; k <= DEPTH; k++)
            if (writes(k, r) && (!pipe[k].ld || k >= LOAD_STAGE) && !(k == 1 && busy > 0))
                return k;
        return 0;
    endfunction

    function automatic bit exp_haz(int r, bit used);
        if (!used) return 0;
        if (bus.forward_EN) begin
            for (int k = 1; k <= DEPTH; k++)
                if (writes(k, r)) return pipe[k].ld && (k < LOAD_STAGE);
            return 0;
        end
        for (int k = 1; k < DEPTH; k++)
            if (writes(k, r)) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit est, eh, iss;
        int es1, es2, einf;
        eh   = (busy > 0);
        es1  = exp_sel(int'(bus.id_src1), bus.id_src1_used);
        es2  = exp_sel(int'(bus.id_src2), bus.id_src2_used);
        est  = bus.id_valid && !bus.flush &&
               (eh || exp_haz(int'(bus.id_src1), bus.id_src1_used) || exp_haz(int'(bus.id_src2), bus.id_src2_used));
        einf = 0;
        for (int k = 1; k <= DEPTH; k++) einf += pipe[k].v;
        if (!rst && seen_rst) begin
            chk("stall", 32'(bus.stall), 32'(est));
            chk("ex_hold", 32'(bus.ex_hold), 32'(eh));
            chk("fwd_sel1", 32'(bus.fwd_sel1), es1);
            chk("fwd_sel2", 32'(bus.fwd_sel2), es2);
            chk("inflight", 32'(bus.inflight), einf);
`ifdef HAZARD_STATS_EN
            chk("stall_cnt", stall_cnt, m_stall);
            chk("hold_cnt", hold_cnt, m_hold);
            chk("fwd_cnt", fwd_cnt, m_fwd);
`endif
        end
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) pipe_n[k] = '{default: 0};
            busy_n = 0;
            m_stall_n = 0; m_hold_n = 0; m_fwd_n = 0;
        end else begin
            m_stall_n = m_stall + int'(est);
            m_hold_n  = m_hold + int'(eh);
            m_fwd_n   = m_fwd + int'(es1 != 0 || es2 != 0);
            if (busy > 0) begin
                pipe_n[1] = pipe[1];
                pipe_n[2] = '{default: 0};
                for (int k = 3; k <= DEPTH; k++) pipe_n[k] = pipe[k-1];
                busy_n = busy - 1;
            end else begin
                for (int k = 2; k <= DEPTH; k++) pipe_n[k] = pipe[k-1];
                iss = bus.id_valid && !bus.flush && !est;
                pipe_n[1] = '{v: iss, wb: bus.id_wb_en, ld: bus.id_is_load, dest: int'(bus.id_dest)};
                busy_n = (iss && bus.id_multi) ? MULTI_LAT - 1 : 0;
            end
        end
    end

    always @(posedge clk) begin
        pipe    = pipe_n;
        busy    = busy_n;
        m_stall = m_stall_n;
        m_hold  = m_hold_n;
        m_fwd   = m_fwd_n;
        if (rst) seen_rst = 1'b1;
    end

    // Applies one cycle of ID inputs and leaves time for the outputs to settle before any pin check.
    task automatic drive(bit fe, bit vld, int s1, bit u1, int s2, bit u2,
                         int d, bit wb, bit ld, bit mul, bit fl);
        @(posedge clk);
        #1;
        bus.forward_EN   = fe;
        bus.id_valid     = vld;
        bus.id_src1      = RAL'(s1);
        bus.id_src1_used = u1;
        bus.id_src2      = RAL'(s2);
        bus.id_src2_used = u2;
        bus.id_dest      = RAL'(d);
        bus.id_wb_en     = wb;
        bus.id_is_load   = ld;
        bus.id_multi     = mul;
        bus.flush        = fl;
        #2;
    endtask

    task automatic idle(int n, bit fe);
        for (int i = 0; i < n; i++) drive(fe, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.forward_EN = 1; bus.id_valid = 0; bus.id_src1 = '0; bus.id_src2 = '0;
        bus.id_src1_used = 0; bus.id_src2_used = 0; bus.id_dest = '0; bus.id_wb_en = 0;
        bus.id_is_load = 0; bus.id_multi = 0; bus.flush = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1, 1);
        chk("reset stall", 32'(bus.stall), 0);
        chk("reset ex_hold", 32'(bus.ex_hold), 0);
        chk("reset inflight", 32'(bus.inflight), 0);
        chk("reset fwd_sel1", 32'(bus.fwd_sel1), 0);

        // ADD r3 then two readers: forwarded from stage 1, then stage 2
        drive(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        chk("t1 issue stall", 32'(bus.stall), 0);
        drive(1, 1, 3, 1, 0, 0, 7, 1, 0, 0, 0);
        chk("t1 fwd_sel1 stage1", 32'(bus.fwd_sel1), 1);
        chk("t1 no stall", 32'(bus.stall), 0);
        drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t1 fwd_sel1 stage2", 32'(bus.fwd_sel1), 2);
        chk("t1 inflight", 32'(bus.inflight), 2);
        idle(4, 1);
        chk("drain inflight", 32'(bus.inflight), 0);

        // filler, LD r5, then load-use on src2
        drive(1, 1, 0, 0, 0, 0, 8, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        chk("t2 load-use stall", 32'(bus.stall), 1);
        chk("t2 fwd_sel2 blocked", 32'(bus.fwd_sel2), 0);
        drive(1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        chk("t2 stall released", 32'(bus.stall), 0);
        chk("t2 fwd_sel2 stage2", 32'(bus.fwd_sel2), 2);
        chk("t2 inflight", 32'(bus.inflight), 2);
        idle(4, 0);

        // forwarding off: dependent waits out stages 1 and 2
        drive(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        drive(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t3 stall c1", 32'(bus.stall), 1);
        drive(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t3 stall c2", 32'(bus.stall), 1);
        drive(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t3 issue c3", 32'(bus.stall), 0);
        chk("t3 fwd_sel1 off", 32'(bus.fwd_sel1), 0);
        idle(4, 1);

        // MUL r6 holds EXE for MULTI_LAT-1 cycles
        drive(1, 1, 0, 0, 0, 0, 6, 1, 0, 1, 0);
        chk("t4 mul issue", 32'(bus.stall), 0);
        for (int i = 0; i < MULTI_LAT - 1; i++) begin
            drive(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
            chk("t4 ex_hold", 32'(bus.ex_hold), 1);
            chk("t4 dep stall", 32'(bus.stall), 1);
        end
        drive(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t4 hold done", 32'(bus.ex_hold), 0);
        chk("t4 dep issues", 32'(bus.stall), 0);
        drive(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t4 fwd_sel1 stage2", 32'(bus.fwd_sel1), 2);
        idle(4, 1);

        // flush beats load-use; flushed instruction leaves no entry
        drive(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 5, 1, 9, 1, 0, 0, 1);
        chk("t5 flush stall", 32'(bus.stall), 0);
        drive(1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t5 flushed no fwd", 32'(bus.fwd_sel1), 0);
        chk("t5 inflight", 32'(bus.inflight), 1);
        idle(2, 1);
        chk("t5 drained", 32'(bus.inflight), 0);

        // r0 never matches; reset aborts a multi-cycle op
        drive(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("t6 r0 stall", 32'(bus.stall), 0);
        chk("t6 r0 fwd_sel1", 32'(bus.fwd_sel1), 0);
        drive(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("t6 r0 stall nofwd", 32'(bus.stall), 0);
        drive(1, 1, 0, 0, 0, 0, 6, 1, 0, 1, 0);
        idle(1, 1);
        chk("t6 mul hold", 32'(bus.ex_hold), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("t6 rst ex_hold", 32'(bus.ex_hold), 0);
        chk("t6 rst inflight", 32'(bus.inflight), 0);

        // random traffic with small register range to force hits; model checks each cycle
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        idle(4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
